// File: rtl/mem_access_unit.sv
// Load/store controller for a byte-addressed 32-bit data memory.
// Sub-word stores are done as a read-modify-write; load results are sign- or zero-extended.
module mem_access_unit #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              mem_wr_q;

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                            input logic uns);
        case (sz)
            SZ_BYTE: extract = {{24{~uns & d[7]}}, d[7:0]};
            SZ_HALF: extract = {{16{~uns & d[15]}}, d[15:0]};
            default: extract = d;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] d, input logic [31:0] w,
                                          input logic [1:0] sz);
        merge = (sz == SZ_BYTE) ? {d[31:8], w[7:0]} : {d[31:16], w[15:0]};
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold value first so no branch can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    if (req_size == SZ_ILL) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (req_we && req_size == SZ_WORD) begin
                        state_d     = WRITE;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    // Read data is consumed straight off the bus on the final wait cycle.
                    if (we_q) begin
                        state_d     = WRITE;
                        mem_wdata_d = merge(mem_rdata, wdata_q, size_q);
                    end else begin
                        state_d     = RESP;
                        rsp_rdata_d = extract(mem_rdata, size_q, uns_q);
                        rsp_err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            cnt_q       <= 2'd0;
            mem_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_wr_q    <= (state_d == WRITE);
        end
    end

    // Write strobe comes from its own flop so it cannot glitch during state decode.
    assign mem_wr    = mem_wr_q;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory, directed vector table, reset and
// back-to-back sequences, then random traffic checked against a byte-level reference model.
module tb_mem_access_unit;

    localparam int RL      = 1;
    localparam int LD_LAT  = RL + 1;
    localparam int SW_LAT  = 2;
    localparam int SUB_LAT = RL + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LATENCY(RL), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    logic [7:0] mem_bytes [logic [31:0]];
    logic [7:0] ref_bytes [logic [31:0]];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ak = a + 32'(k);
            w[8*k +: 8] = mem_bytes.exists(ak) ? mem_bytes[ak] : 8'h00;
        end
        return w;
    endfunction

    // Memory: read data appears RL cycles after the address settles; writes land on the edge.
    logic [31:0] raddr_dly [0:3];
    always @(posedge clk) begin
        raddr_dly[0] <= mem_raddr;
        for (int i = 1; i < 4; i++) raddr_dly[i] <= raddr_dly[i-1];
        if (mem_wr)
            for (int k = 0; k < 4; k++) mem_bytes[mem_waddr + 32'(k)] = mem_wdata[8*k +: 8];
    end
    always @(negedge clk)
        mem_rdata <= mem_word((RL == 1) ? mem_raddr : raddr_dly[(RL >= 2) ? RL - 2 : 0]);

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_bytes.exists(a) ? ref_bytes[a] : 8'h00;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
        int n = size_bytes(sz);
        logic [31:0] v = 32'd0;
        logic [31:0] mask;
        for (int k = 0; k < n; k++) v = v | (32'(ref_byte(a + 32'(k))) << (8 * k));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int k = 0; k < size_bytes(sz); k++) ref_bytes[a + 32'(k)] = d[8*k +: 8];
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            mem_bytes[a + 32'(k)] = d[8*k +: 8];
            ref_bytes[a + 32'(k)] = d[8*k +: 8];
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d;
    endtask

    task automatic run_op(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wr, input logic [31:0] exp_wdata);
        int lat = 0, wr_cnt = 0, wr_cyc = 0;
        logic [31:0] wa = 32'd0, wd = 32'd0, rd = 32'd0;
        logic er = 1'b0;
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        drive(we, sz, uns, a, d);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 30 && lat == 0; n++) begin
            @(negedge clk);
            if (mem_wr) begin wr_cnt++; wa = mem_waddr; wd = mem_wdata; wr_cyc = n; end
            if (rsp_valid) begin lat = n; rd = rsp_rdata; er = rsp_err; end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rd, exp_rdata);
        check({tag, " err"}, 32'(er), 32'(exp_err));
        check({tag, " wr_count"}, 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr > 0) begin
            check({tag, " waddr"}, wa, a);
            check({tag, " wdata"}, wd, exp_wdata);
            check({tag, " wr_cycle"}, 32'(wr_cyc), 32'(exp_lat - 1));
        end
        @(negedge clk);
        check({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, " rdata_hold"}, rsp_rdata, exp_rdata);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr;
        logic [31:0] wr_data;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] rdata, input logic err, input int lat,
                                input int wr, input logic [31:0] wr_data);
        vec_t v;
        v.name = nm; v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = d;
        v.rdata = rdata; v.err = err; v.lat = lat; v.wr = wr; v.wr_data = wr_data;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        poke(32'h200, 32'h0000_0080);
        poke(32'h210, 32'h0000_8001);
        poke(32'h300, 32'h1122_3344);
        poke(32'hFFFF_FFFE, 32'hA1B2_C3D4);

        tbl.push_back(mk("sw",       1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, SW_LAT, 1, 32'hDEAD_BEEF));
        tbl.push_back(mk("lw",       0, 2'd2, 0, 32'h100, 0, 32'hDEAD_BEEF, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lw_uns",   0, 2'd2, 1, 32'h100, 0, 32'hDEAD_BEEF, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lb",       0, 2'd0, 0, 32'h200, 0, 32'hFFFF_FF80, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lbu",      0, 2'd0, 1, 32'h200, 0, 32'h0000_0080, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lh",       0, 2'd1, 0, 32'h210, 0, 32'hFFFF_8001, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lhu",      0, 2'd1, 1, 32'h210, 0, 32'h0000_8001, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("sb",       1, 2'd0, 0, 32'h300, 32'h5555_55AB, 0, 0, SUB_LAT, 1, 32'h1122_33AB));
        tbl.push_back(mk("lw_sb",    0, 2'd2, 0, 32'h300, 0, 32'h1122_33AB, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("sh",       1, 2'd1, 0, 32'h300, 32'h9999_CDEF, 0, 0, SUB_LAT, 1, 32'h1122_CDEF));
        tbl.push_back(mk("lw_sh",    0, 2'd2, 0, 32'h300, 0, 32'h1122_CDEF, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("ill_ld",   0, 2'd3, 0, 32'h300, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("ill_st",   1, 2'd3, 0, 32'h300, 32'hFFFF_FFFF, 0, 1, 1, 0, 0));
        tbl.push_back(mk("lw_ill",   0, 2'd2, 0, 32'h300, 0, 32'h1122_CDEF, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lw_unal",  0, 2'd2, 0, 32'h301, 0, 32'h0011_22CD, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lw_wrap",  0, 2'd2, 0, 32'hFFFF_FFFE, 0, 32'hA1B2_C3D4, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lhu_wrap", 0, 2'd1, 1, 32'hFFFF_FFFF, 0, 32'h0000_B2C3, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("lb_wrap",  0, 2'd0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFC3, 0, LD_LAT, 0, 0));
        tbl.push_back(mk("sh_wrap",  1, 2'd1, 0, 32'hFFFF_FFFF, 32'h0000_1234, 0, 0, SUB_LAT, 1, 32'h00A1_1234));
        tbl.push_back(mk("lw_wrap2", 0, 2'd2, 0, 32'hFFFF_FFFE, 0, 32'hA112_34D4, 0, LD_LAT, 0, 0));

        // Reset held with a request pending: nothing accepted, outputs at reset values.
        drive(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst mem_wr", 32'(mem_wr), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst raddr", mem_raddr, 32'd0);
        check("rst wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("post_rst accept", 32'(req_ready), 32'd0);
        check("post_rst raddr", mem_raddr, 32'h100);
        lat = 0;
        for (int n = 2; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (rsp_valid) lat = n - 1;
        end
        check("post_rst latency", 32'(lat), 32'(LD_LAT));
        check("post_rst rdata", rsp_rdata, 32'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].name, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                   tbl[i].rdata, tbl[i].err, tbl[i].lat, tbl[i].wr, tbl[i].wr_data);
            if (tbl[i].we && tbl[i].size != 2'd3) ref_store(tbl[i].addr, tbl[i].size, tbl[i].wdata);
        end

        // Reset during the read phase of a byte store: the write must never happen.
        begin
            int wr_seen = 0, rsp_seen = 0;
            @(negedge clk);
            drive(1'b1, 2'd0, 1'b0, 32'h300, 32'h0000_0077);
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (mem_wr) wr_seen++;
                if (rsp_valid) rsp_seen++;
            end
            check("midrst wr", 32'(wr_seen), 32'd0);
            check("midrst rsp", 32'(rsp_seen), 32'd0);
            check("midrst ready", 32'(req_ready), 32'd1);
            rst_n = 1'b1;
            run_op("midrst lw", 1'b0, 2'd2, 1'b0, 32'h300, 32'd0,
                   ref_load(32'h300, 2'd2, 1'b0), 1'b0, LD_LAT, 0, 32'd0);
        end

        // Two loads with req_valid held: second accept only in the IDLE after RESP.
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        for (int i = 0; i < 2 * (RL + 2); i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("b2b ready[%0d]", i), 32'(req_ready), 32'((i % (RL + 2)) == 0));
            check($sformatf("b2b rsp[%0d]", i), 32'(rsp_valid), 32'((i % (RL + 2)) == RL + 1));
            if ((i % (RL + 2)) == RL + 1)
                check($sformatf("b2b rdata[%0d]", i), rsp_rdata, 32'hDEAD_BEEF);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1 check("b2b idle_after", 32'(req_ready), 32'd1);

        // Random traffic in a small window so loads revisit stored bytes.
        for (int a = 32'h400; a < 32'h410; a += 4) poke(32'(a), $urandom);
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  r   = 3'($urandom_range(0, 7));
            logic [1:0]  sz  = (r == 3'd7) ? 2'd3 : 2'(r % 3'd3);
            logic        we  = 1'($urandom_range(0, 1));
            logic        uns = 1'($urandom_range(0, 1));
            logic [31:0] a   = 32'h400 + 32'($urandom_range(0, 11));
            logic [31:0] d   = $urandom;
            string       tag = $sformatf("rnd%0d", i);
            if (sz == 2'd3) begin
                run_op(tag, we, sz, uns, a, d, 32'd0, 1'b1, 1, 0, 32'd0);
            end else if (!we) begin
                run_op(tag, we, sz, uns, a, d, ref_load(a, sz, uns), 1'b0, LD_LAT, 0, 32'd0);
            end else begin
                ref_store(a, sz, d);
                run_op(tag, we, sz, uns, a, d, 32'd0, 1'b0,
                       (sz == 2'd2) ? SW_LAT : SUB_LAT, 1, ref_load(a, 2'd2, 1'b0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
